// File: rtl/msg_scroller_if.sv
// Control/status bundle between the scroller and whoever drives it.
// The display buffer rides along so the display decoder can tap it.
interface msg_scroller_if #(
  parameter int CHAR_W     = 5,
  parameter int DISP_CHARS = 8
);
  logic                         start;
  logic [1:0]                   msg_sel;
  logic                         loop;
  logic                         pause;
  logic                         busy;
  logic                         done;
  logic                         shift_strobe;
  logic [CHAR_W*DISP_CHARS-1:0] instruction;

  modport master (
    output start, msg_sel, loop, pause,
    input  busy, done, shift_strobe, instruction
  );

  modport slave (
    input  start, msg_sel, loop, pause,
    output busy, done, shift_strobe, instruction
  );
endinterface

// File: rtl/msg_scroller.sv
// Scrolling-text generator: shifts a ROM message into the display buffer
// one character per clock, then shifts blanks to clear it; optional looping.
module msg_scroller #(
  parameter int CHAR_W      = 5,
  parameter int DISP_CHARS  = 8,
  parameter int TAIL_BLANKS = 8
) (
  input logic           sec_clock,
  input logic           rst,
  msg_scroller_if.slave bus
);
  localparam int W  = CHAR_W * DISP_CHARS;
  localparam int TW = (TAIL_BLANKS > 1) ? $clog2(TAIL_BLANKS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t          state, state_n;
  logic [1:0]      sel;
  logic [3:0]      idx;
  logic [TW-1:0]   tcnt;
  logic [W-1:0]    buf_q;
  logic            busy_q, done_q, strobe_q;
  logic            shift_en, end_pass, last_char;
  logic [59:0]     row;
  logic [6:0]      bitpos;
  logic [4:0]      rom_chr;
  logic [3:0]      len;
  logic [CHAR_W-1:0] code;

  // Each message packed with character 0 in the LSBs, 5 bits per character.
  function automatic logic [59:0] rom_row(input logic [1:0] s);
    case (s)
      2'd0:    rom_row = {5'd5, 5'd3, 5'd14, 5'd1, 5'd12, 5'd1, 5'd2, 5'd0,
                          5'd23, 5'd15, 5'd8, 5'd19};
      2'd1:    rom_row = {25'd0, 5'd20, 5'd9, 5'd19, 5'd15, 5'd16, 5'd5, 5'd4};
      2'd2:    rom_row = {20'd0, 5'd23, 5'd1, 5'd18, 5'd4, 5'd8, 5'd20, 5'd9, 5'd23};
      default: rom_row = {5'd0, 5'd4, 5'd18, 5'd1, 5'd3, 5'd0, 5'd20, 5'd18,
                          5'd5, 5'd19, 5'd14, 5'd9};
    endcase
  endfunction

  function automatic logic [3:0] rom_len(input logic [1:0] s);
    case (s)
      2'd0:    rom_len = 4'd12;
      2'd1:    rom_len = 4'd7;
      2'd2:    rom_len = 4'd8;
      default: rom_len = 4'd11;
    endcase
  endfunction

  always_comb begin
    row       = rom_row(sel);
    len       = rom_len(sel);
    bitpos    = {3'b000, idx} * 7'd5;
    rom_chr   = row[bitpos +: 5];
    last_char = (idx == len - 4'd1);
  end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    end_pass = 1'b0;
    code     = '0;
    case (state)
      IDLE:  if (bus.start) state_n = SHIFT;
      SHIFT: if (!bus.pause) begin
        shift_en = 1'b1;
        code     = CHAR_W'(rom_chr);
        if (last_char) state_n = TAIL;
      end
      TAIL:  if (!bus.pause) begin
        shift_en = 1'b1;
        if (tcnt == TW'(TAIL_BLANKS - 1)) begin
          end_pass = 1'b1;
          state_n  = bus.loop ? SHIFT : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sec_clock) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge sec_clock) begin
    if (rst) begin
      sel      <= '0;
      idx      <= '0;
      tcnt     <= '0;
      buf_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= shift_en;
      done_q   <= end_pass;
      if (shift_en) buf_q <= (buf_q << CHAR_W) | W'(code);
      case (state)
        IDLE: if (bus.start) begin
          sel    <= bus.msg_sel;
          idx    <= '0;
          buf_q  <= '0;
          busy_q <= 1'b1;
        end
        SHIFT: if (!bus.pause) begin
          if (last_char) tcnt <= '0;
          else           idx  <= idx + 4'd1;
        end
        TAIL: if (!bus.pause) begin
          // Loop decision is taken on the same edge as the last blank.
          if (end_pass) begin
            idx <= '0;
            if (!bus.loop) busy_q <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.shift_strobe = strobe_q;
  assign bus.instruction  = buf_q;
endmodule

// File: tb/tb_msg_scroller.sv
// Scoreboard bench for msg_scroller: expected buffer snapshots come from a
// character-stream model; a monitor pops one per observed shift strobe.
module tb_msg_scroller;
  localparam int CW = 5, DC = 8, TB = 8, W = CW * DC;

  logic sec_clock = 1'b0;
  logic rst;

  msg_scroller_if #(.CHAR_W(CW), .DISP_CHARS(DC)) bus ();
  msg_scroller #(.CHAR_W(CW), .DISP_CHARS(DC), .TAIL_BLANKS(TB)) dut (
    .sec_clock(sec_clock), .rst(rst), .bus(bus)
  );

  always #5 sec_clock = ~sec_clock;

  typedef struct { logic [W-1:0] instr; logic last; logic busy; } exp_t;

  exp_t sbq[$];
  int   stream[$];
  int   done_cyc[$];
  int   errors = 0, checks = 0, cyc = 0, nshifts = 0, passes_left = 0;
  logic [W-1:0] prev_instr = '0;

  int msg_len [4] = '{12, 7, 8, 11};
  int msg_txt [4][12] = '{
    '{19, 8, 15, 23, 0, 2, 1, 12, 1, 14, 3, 5},
    '{4, 5, 16, 15, 19, 9, 20, 0, 0, 0, 0, 0},
    '{23, 9, 20, 8, 4, 18, 1, 23, 0, 0, 0, 0},
    '{9, 14, 19, 5, 18, 20, 0, 3, 1, 18, 4, 0}
  };

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Display shows the last DC characters of everything shifted since start.
  function automatic logic [W-1:0] window();
    logic [W-1:0] w = '0;
    for (int j = 0; j < DC; j++)
      if (stream.size() > j) w[j*CW +: CW] = CW'(stream[stream.size()-1-j]);
    return w;
  endfunction

  task automatic push_passes(input int sel, input int passes);
    exp_t e;
    int   n;
    stream.delete();
    n = msg_len[sel] + TB;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++) begin
        stream.push_back(i < msg_len[sel] ? msg_txt[sel][i] : 0);
        e.instr = window();
        e.last  = (i == n - 1);
        e.busy  = !(e.last && p == passes - 1);
        sbq.push_back(e);
      end
  endtask

  // Monitor: samples just after each rising edge.
  always @(posedge sec_clock) begin
    exp_t e;
    cyc++;
    #1;
    if (bus.shift_strobe) begin
      nshifts++;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_shift: got shift with instr %0h, expected no shift (cycle %0d)",
                 bus.instruction, cyc);
      end else begin
        e = sbq.pop_front();
        chk("instruction", bus.instruction, e.instr);
        chk("done_at_pass_end", W'(bus.done), W'(e.last));
        chk("busy_after_shift", W'(bus.busy), W'(e.busy));
      end
    end else begin
      chk("done_without_shift", W'(bus.done), '0);
      if (!rst && bus.instruction != '0) chk("held_buffer", bus.instruction, prev_instr);
    end
    if (bus.done) done_cyc.push_back(cyc);
    prev_instr = bus.instruction;
  end

  task automatic start_msg(input int sel, input int passes, output int k);
    @(negedge sec_clock);
    push_passes(sel, passes);
    nshifts     = 0;
    passes_left = passes;
    done_cyc.delete();
    bus.msg_sel = 2'(sel);
    bus.loop    = (passes > 1);
    bus.start   = 1'b1;
    @(negedge sec_clock);
    k = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input bit rnd);
    int n = 0;
    while (bus.busy && n < limit) begin
      if (bus.done) begin
        passes_left--;
        bus.loop = (passes_left > 1);
      end
      if (rnd) begin
        bus.pause   = ($urandom_range(0, 3) == 0);
        bus.start   = ($urandom_range(0, 7) == 0);
        bus.msg_sel = 2'($urandom_range(0, 3));
      end
      @(negedge sec_clock);
      n++;
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    chk("completion_timeout", W'(bus.busy), '0);
    chk("scoreboard_drained", W'(sbq.size()), '0);
  endtask

  task automatic show_balance();
    int k;
    start_msg(0, 1, k);
    while (cyc < k + 8) @(negedge sec_clock);
    chk("show_bal_8_shifts", bus.instruction, W'(40'h9A1F70082C));
    wait_idle(100, 1'b0);
    chk("s1_pass_count", W'(done_cyc.size()), W'(1));
    if (done_cyc.size() > 0) chk("s1_done_cycle", W'(done_cyc[0]), W'(k + 20));
    chk("s1_shift_count", W'(nshifts), W'(20));
    chk("s1_cleared", bus.instruction, '0);
  endtask

  initial begin
    int k;
    logic [W-1:0] snap;
    rst = 1'b1;
    bus.start = 1'b0; bus.msg_sel = 2'd0; bus.loop = 1'b0; bus.pause = 1'b0;
    repeat (3) @(negedge sec_clock);
    chk("reset_instruction", bus.instruction, '0);
    chk("reset_busy", W'(bus.busy), '0);
    chk("reset_done", W'(bus.done), '0);
    chk("reset_strobe", W'(bus.shift_strobe), '0);
    rst = 1'b0;

    show_balance();

    start_msg(1, 1, k);
    while (cyc < k + 7) @(negedge sec_clock);
    chk("deposit_7_shifts", bus.instruction, W'(40'h010B07CD34));
    wait_idle(100, 1'b0);
    if (done_cyc.size() > 0) chk("deposit_done_cycle", W'(done_cyc[0]), W'(k + 15));

    start_msg(2, 3, k);
    wait_idle(200, 1'b0);
    chk("withdraw_pass_count", W'(done_cyc.size()), W'(3));
    for (int i = 0; i < done_cyc.size() && i < 3; i++)
      chk("withdraw_done_cycle", W'(done_cyc[i]), W'(k + 16 * (i + 1)));

    // Pause after the 3rd shift; a stray start mid-message must be ignored.
    start_msg(3, 1, k);
    while (cyc < k + 3) @(negedge sec_clock);
    snap = bus.instruction;
    bus.pause = 1'b1;
    repeat (5) @(negedge sec_clock);
    bus.pause = 1'b0;
    chk("pause_freeze", bus.instruction, snap);
    chk("pause_shift_count", W'(nshifts), W'(3));
    while (cyc < k + 12) @(negedge sec_clock);
    bus.msg_sel = 2'd0;
    bus.start   = 1'b1;
    @(negedge sec_clock);
    bus.start   = 1'b0;
    wait_idle(100, 1'b0);
    if (done_cyc.size() > 0) chk("insert_card_done_cycle", W'(done_cyc[0]), W'(k + 24));
    chk("insert_card_shifts", W'(nshifts), W'(19));

    start_msg(0, 1, k);
    while (cyc < k + 6) @(negedge sec_clock);
    chk("shifts_before_reset", W'(nshifts), W'(6));
    rst = 1'b1;
    sbq.delete();
    @(negedge sec_clock);
    chk("midrst_instruction", bus.instruction, '0);
    chk("midrst_busy", W'(bus.busy), '0);
    chk("midrst_done", W'(bus.done), '0);
    rst = 1'b0;
    show_balance();

    for (int r = 0; r < 12; r++) begin
      int sel, passes;
      sel    = $urandom_range(0, 3);
      passes = $urandom_range(1, 3);
      start_msg(sel, passes, k);
      wait_idle(400, 1'b1);
      chk("rand_pass_count", W'(done_cyc.size()), W'(passes));
    end

    repeat (5) @(negedge sec_clock);
    chk("final_idle_busy", W'(bus.busy), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
